// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, FSM state type and PC helpers.
// Build option FETCH_MISALIGN_EN adds the HALT state used for misaligned redirect targets.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_ENC  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

`ifdef FETCH_MISALIGN_EN
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [0:0] {
        FS_REQ  = 1'b0,
        FS_WAIT = 1'b1
    } fetch_state_t;
`endif

    // Sequential fetch address; 32-bit arithmetic wraps past the top of memory.
    function automatic logic [31:0] seqPc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    // Redirect targets are word aligned unless the misalign trap path is built in.
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load has priority over clear; a cleared entry
// presents the NOP encoding so the decoder never sees stale instruction bits.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;

    // The PC is left untouched on clear; only valid and the instruction word matter then.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= 32'h0000_0000;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, drop flag for
// squashed responses, and the IF/ID register. Option: FETCH_MISALIGN_EN (misalign trap + HALT).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
`ifdef FETCH_MISALIGN_EN
    input  logic [31:0] redirect_pc,
    output logic        id_misalign
`else
    input  logic [31:0] redirect_pc
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_stateNext;
    logic [31:0]  r_pc;
    logic [31:0]  w_pcNext;
    logic         r_drop;
    logic         w_dropNext;

    logic         w_load;
    logic         w_clear;
    logic [31:0]  w_loadInst;
    logic [31:0]  w_loadPc;
    logic [31:0]  w_redirPc;
    logic         w_issueOk;
    logic         w_reqValid;
    logic         w_accept;
    logic         w_respExpected;
    logic         w_respNow;
    logic         w_stillPending;
    logic         w_consume;

`ifdef FETCH_MISALIGN_EN
    logic         w_misRedir;
    logic         r_misalign;

    assign w_redirPc  = redirect_pc;
    assign w_misRedir = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // A halted fetch may still owe a squashed response from before the redirect.
    assign w_respExpected = (r_state == FS_WAIT) || ((r_state == FS_HALT) && r_drop);
`else
    logic         w_unused;

    assign w_redirPc      = alignPc(redirect_pc);
    assign w_unused       = ^redirect_pc[1:0];
    assign w_respExpected = (r_state == FS_WAIT);
`endif

    assign w_consume      = id_valid && id_ready;
    assign w_issueOk      = !id_valid || id_ready;
    assign w_reqValid     = !reset && (r_state == FS_REQ) && w_issueOk;
    assign w_accept       = w_reqValid && imem_req_ready;
    assign w_respNow      = w_respExpected && imem_resp_valid;
    // After this cycle, does memory still owe us a response that must be thrown away?
    assign w_stillPending = (w_respExpected && !imem_resp_valid) || w_accept;

    assign imem_req_valid = w_reqValid;
    assign imem_addr      = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FS_REQ;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            r_drop  <= w_dropNext;
        end
    end

    // Redirect outranks everything; otherwise the FSM advances on accept/response.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_dropNext  = r_drop;
        w_load      = 1'b0;
        w_loadInst  = imem_resp_data;
        w_loadPc    = r_pc;

        if (redirect_valid) begin
            w_pcNext    = w_redirPc;
            w_dropNext  = w_stillPending;
            w_stateNext = w_stillPending ? FS_WAIT : FS_REQ;
`ifdef FETCH_MISALIGN_EN
            if (w_misRedir) begin
                w_load      = 1'b1;
                w_loadInst  = NOP_INST;
                w_loadPc    = redirect_pc;
                w_stateNext = FS_HALT;
            end
`endif
        end else begin
            case (r_state)
                FS_REQ: begin
                    if (w_accept) begin
                        w_stateNext = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (w_respNow) begin
                        w_stateNext = FS_REQ;
                        if (r_drop) begin
                            w_dropNext = 1'b0;
                        end else begin
                            w_load   = 1'b1;
                            w_pcNext = seqPc(r_pc);
                        end
                    end
                end
`ifdef FETCH_MISALIGN_EN
                FS_HALT: begin
                    if (w_respNow) begin
                        w_dropNext = 1'b0;
                    end
                end
`endif
                default: begin
                    w_stateNext = FS_REQ;
                end
            endcase
        end
    end

    // A fill never coincides with a live entry, so clearing on consume is safe.
    assign w_clear = redirect_valid || w_consume;

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign <= w_misRedir;
        end else if (w_consume) begin
            r_misalign <= 1'b0;
        end
    end

    assign id_misalign = r_misalign;
`endif

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_inst  (w_loadInst),
        .i_pc    (w_loadPc),
        .o_valid (id_valid),
        .o_inst  (id_inst),
        .o_pc    (id_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// checked against a program-order model of which PCs the decoder should receive.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_MISALIGN_EN
    logic        id_misalign;
`endif

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_ready        (id_ready),
        .redirect_valid  (redirect_valid),
`ifdef FETCH_MISALIGN_EN
        .redirect_pc     (redirect_pc),
        .id_misalign     (id_misalign)
`else
        .redirect_pc     (redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    // Reference state: next PC the decoder must see, plus a one-deep memory model.
    logic [31:0] modelPc = 32'h0;
    int          consumed = 0;
    logic        memPending = 1'b0;
    int          memCount = 0;
    logic [31:0] memAddr = 32'h0;
    logic        prevStall = 1'b0;
    logic [31:0] prevInst = 32'h0;
    logic [31:0] prevPc = 32'h0;
    logic        sawReq = 1'b0;
    logic        modelHalt = 1'b0;
    logic        haltDone = 1'b0;
    logic [31:0] accLog[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check what the DUT presents, then advance past the edge.
    task automatic runCycle(input logic rdy, input logic rv, input logic [31:0] rpc,
                            input logic memRdy, input int lat);
        logic        sReqV;
        logic [31:0] sAddr;
        logic        sIdV;
        logic [31:0] sInst;
        logic [31:0] sPc;
        logic        respGiven;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = memRdy;
        if (memPending && memCount == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memf(memAddr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        sReqV = imem_req_valid;
        sAddr = imem_addr;
        sIdV  = id_valid;
        sInst = id_inst;
        sPc   = id_pc;
        if (sReqV) sawReq = 1'b1;

        if (!sIdV) check("empty_is_nop", sInst, NOP);
        if (prevStall) begin
            check("stall_inst", sInst, prevInst);
            check("stall_pc", sPc, prevPc);
        end
        if (sIdV && !rdy) check("stall_no_req", {31'b0, sReqV}, 32'd0);
        if (modelHalt) check("halt_no_req", {31'b0, sReqV}, 32'd0);
        if (haltDone) check("halt_empty", {31'b0, sIdV}, 32'd0);

        if (sIdV && rdy) begin
            check("id_pc", sPc, modelPc);
            check("id_inst", sInst, modelHalt ? NOP : memf(modelPc));
            if (modelHalt) haltDone = 1'b1;
            modelPc = modelPc + 32'd4;
            consumed++;
        end
        if (rv) begin
            haltDone = 1'b0;
`ifdef FETCH_MISALIGN_EN
            modelHalt = (rpc[1:0] != 2'b00);
            modelPc   = rpc;
`else
            modelHalt = 1'b0;
            modelPc   = rpc & ~32'h3;
`endif
        end

        respGiven = imem_resp_valid;
        if (respGiven) memPending = 1'b0;
        else if (memPending) memCount--;
        if (sReqV && memRdy) begin
            check("one_outstanding", {31'b0, memPending}, 32'd0);
            memPending = 1'b1;
            memAddr    = sAddr;
            memCount   = lat;
            accLog.push_back(sAddr);
        end

        prevStall = sIdV && !rdy && !rv;
        prevInst  = sInst;
        prevPc    = sPc;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        reset           = 1'b1;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_id_inst", id_inst, NOP);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        reset      = 1'b0;
        memPending = 1'b0;
        modelPc    = 32'h0;
        prevStall  = 1'b0;
        modelHalt  = 1'b0;
        haltDone   = 1'b0;
    endtask

    initial begin
        int idx;
        int c0;
        logic [31:0] rpc;

        $display("[TB] reset");
        applyReset(3);
        check("rst_addr", imem_addr, 32'h0);

        $display("[TB] streaming with zero-wait memory");
        idx = accLog.size();
        c0  = consumed;
        for (int i = 0; i < 24; i++) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 0);
        check("t1_rate", consumed - c0, 11);
        check("t1_addr0", accLog[idx], 32'h0);
        check("t1_addr1", accLog[idx+1], 32'h4);
        check("t1_addr2", accLog[idx+2], 32'h8);

        $display("[TB] decode stall");
        for (int i = 0; i < 10 && !id_valid; i++) runCycle(1'b0, 1'b0, 32'h0, 1'b1, 0);
        check("t2_setup_valid", {31'b0, id_valid}, 32'd1);
        sawReq = 1'b0;
        for (int i = 0; i < 5; i++) runCycle(1'b0, 1'b0, 32'h0, 1'b1, 0);
        check("t2_no_req", {31'b0, sawReq}, 32'd0);
        check("t2_valid", {31'b0, id_valid}, 32'd1);
        check("t2_pc", id_pc, modelPc);
        check("t2_inst", id_inst, memf(modelPc));

        $display("[TB] redirect while waiting");
        for (int i = 0; i < 10; i++) begin
            runCycle(1'b1, 1'b0, 32'h0, 1'b1, 1);
            if (memPending && memCount == 1) break;
        end
        check("t3_setup", {31'b0, memPending}, 32'd1);
        idx = accLog.size();
        c0  = consumed;
        runCycle(1'b1, 1'b1, 32'h100, 1'b1, 0);
        for (int i = 0; i < 6; i++) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 0);
        check("t3_addr", accLog.size() > idx ? accLog[idx] : 32'hDEAD_BEEF, 32'h100);
        check("t3_progress", {31'b0, (consumed - c0) >= 2}, 32'd1);

        $display("[TB] redirect with same-cycle response");
        for (int i = 0; i < 10; i++) begin
            runCycle(1'b1, 1'b0, 32'h0, 1'b1, 1);
            if (memPending && memCount == 0) break;
        end
        check("t4_setup", {31'b0, memPending}, 32'd1);
        runCycle(1'b1, 1'b1, 32'h2000, 1'b1, 0);
        check("t4_id_valid", {31'b0, id_valid}, 32'd0);
        check("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t4_addr", imem_addr, 32'h2000);

        $display("[TB] PC wrap");
        runCycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 0);
        idx = accLog.size();
        for (int i = 0; i < 8; i++) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 0);
        check("t5_addr_top", accLog.size() > idx ? accLog[idx] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("t5_addr_wrap", accLog.size() > idx + 1 ? accLog[idx+1] : 32'hDEAD_BEEF, 32'h0);

        $display("[TB] reset while waiting");
        for (int i = 0; i < 10; i++) begin
            runCycle(1'b1, 1'b0, 32'h0, 1'b1, 2);
            if (memPending && memCount == 2) break;
        end
        applyReset(1);
        idx = accLog.size();
        for (int i = 0; i < 6; i++) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 0);
        check("t6_addr", accLog.size() > idx ? accLog[idx] : 32'hDEAD_BEEF, 32'h0);

`ifdef FETCH_MISALIGN_EN
        $display("[TB] misaligned redirect");
        runCycle(1'b1, 1'b1, 32'h102, 1'b1, 0);
        check("m_valid", {31'b0, id_valid}, 32'd1);
        check("m_inst", id_inst, NOP);
        check("m_pc", id_pc, 32'h102);
        check("m_flag", {31'b0, id_misalign}, 32'd1);
        for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 32'h0, 1'b1, 0);
        runCycle(1'b1, 1'b0, 32'h0, 1'b1, 0);
        check("m_flag_clear", {31'b0, id_misalign}, 32'd0);
        sawReq = 1'b0;
        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 0);
        check("m_halted", {31'b0, sawReq}, 32'd0);
        idx = accLog.size();
        runCycle(1'b1, 1'b1, 32'h200, 1'b0, 0);
        for (int i = 0; i < 6; i++) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 0);
        check("m_resume", accLog.size() > idx ? accLog[idx] : 32'hDEAD_BEEF, 32'h200);
`endif

        $display("[TB] randomized traffic");
        c0 = consumed;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = $urandom & 32'h0000_0FFF;
                1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
`ifdef FETCH_MISALIGN_EN
            rpc = rpc & ~32'h3;
`endif
            runCycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 3));
        end
        check("rand_progress", {31'b0, (consumed - c0) >= 50}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
